// File: rtl/rob.sv
// rtl/rob.sv - circular reorder buffer with tag lookup, writeback and in-order commit
//
// Ports:
//   clk, rst            clock and synchronous active-low reset
//   flush               discard every entry on the next edge
//   id_*                allocation request from ID; id_ready/alloc_id back to ID
//   read_id_n           operand tag lookup; read_ready_n/read_data_n are combinational
//   wb_*                execution result for an entry tag
//   commit_*            registered retirement toward the regfile, one per cycle

module rob #(
    parameter int ROB_DEPTH      = 16,
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [31:0]               id_pc,
    input  logic                      id_reg_write_en,
    input  logic [4:0]                id_reg_write_addr,
    output logic                      id_ready,
    output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
    input  logic [ROB_ADDR_WIDTH-1:0] read_id_1,
    input  logic [ROB_ADDR_WIDTH-1:0] read_id_2,
    output logic                      read_ready_1,
    output logic                      read_ready_2,
    output logic [31:0]               read_data_1,
    output logic [31:0]               read_data_2,
    input  logic                      wb_en,
    input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
    input  logic [31:0]               wb_data,
    output logic                      commit_en,
    output logic [31:0]               commit_pc,
    output logic                      commit_reg_write_en,
    output logic [4:0]                commit_reg_write_addr,
    output logic [31:0]               commit_data
);

    localparam int CW = ROB_ADDR_WIDTH + 1;

    logic [ROB_DEPTH-1:0]      valid_q, valid_d;
    logic [ROB_DEPTH-1:0]      done_q, done_d;
    logic [31:0]               pc_q   [ROB_DEPTH];
    logic                      rwe_q  [ROB_DEPTH];
    logic [4:0]                rwa_q  [ROB_DEPTH];
    logic [31:0]               data_q [ROB_DEPTH];

    logic [ROB_ADDR_WIDTH-1:0] head_q, head_d;
    logic [ROB_ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;

    logic                      commit_en_q, commit_en_d;
    logic [31:0]               commit_pc_q, commit_pc_d;
    logic                      commit_rwe_q, commit_rwe_d;
    logic [4:0]                commit_rwa_q, commit_rwa_d;
    logic [31:0]               commit_data_q, commit_data_d;

    logic do_alloc, do_wb, do_commit;
    logic fwd_1, fwd_2;

    // All three decisions use state at cycle start, so a full buffer that
    // commits this cycle still refuses the allocation.
    assign id_ready  = (count_q != CW'(ROB_DEPTH));
    assign alloc_id  = tail_q;
    assign do_alloc  = id_valid && id_ready;
    assign do_wb     = wb_en && valid_q[wb_id];
    assign do_commit = valid_q[head_q] && done_q[head_q];

    // Same-cycle writeback is forwarded to operand lookups.
    assign fwd_1        = wb_en && (wb_id == read_id_1) && valid_q[read_id_1];
    assign fwd_2        = wb_en && (wb_id == read_id_2) && valid_q[read_id_2];
    assign read_ready_1 = (valid_q[read_id_1] && done_q[read_id_1]) || fwd_1;
    assign read_ready_2 = (valid_q[read_id_2] && done_q[read_id_2]) || fwd_2;
    assign read_data_1  = fwd_1 ? wb_data : data_q[read_id_1];
    assign read_data_2  = fwd_2 ? wb_data : data_q[read_id_2];

    assign commit_en             = commit_en_q;
    assign commit_pc             = commit_pc_q;
    assign commit_reg_write_en   = commit_rwe_q;
    assign commit_reg_write_addr = commit_rwa_q;
    assign commit_data           = commit_data_q;

    always_comb begin
        valid_d       = valid_q;
        done_d        = done_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_en_d   = 1'b0;
        commit_pc_d   = commit_pc_q;
        commit_rwe_d  = commit_rwe_q;
        commit_rwa_d  = commit_rwa_q;
        commit_data_d = commit_data_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_wb) begin
                done_d[wb_id] = 1'b1;
            end
            if (do_commit) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + ROB_ADDR_WIDTH'(1);
                commit_en_d     = 1'b1;
                commit_pc_d     = pc_q[head_q];
                commit_rwe_d    = rwe_q[head_q];
                commit_rwa_d    = rwa_q[head_q];
                commit_data_d   = data_q[head_q];
            end
            // The tail entry is never the committing head here: a valid head
            // with room to allocate implies tail != head.
            if (do_alloc) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + ROB_ADDR_WIDTH'(1);
            end
            count_d = count_q + CW'(do_alloc) - CW'(do_commit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q       <= '0;
            done_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_en_q   <= 1'b0;
            commit_pc_q   <= '0;
            commit_rwe_q  <= 1'b0;
            commit_rwa_q  <= '0;
            commit_data_q <= '0;
        end else begin
            valid_q       <= valid_d;
            done_q        <= done_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_en_q   <= commit_en_d;
            commit_pc_q   <= commit_pc_d;
            commit_rwe_q  <= commit_rwe_d;
            commit_rwa_q  <= commit_rwa_d;
            commit_data_q <= commit_data_d;
        end
    end

    // Payload storage needs no reset: it is only observed behind valid/done.
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            if (do_alloc) begin
                pc_q[tail_q]  <= id_pc;
                rwe_q[tail_q] <= id_reg_write_en;
                rwa_q[tail_q] <= id_reg_write_addr;
            end
            if (do_wb) begin
                data_q[wb_id] <= wb_data;
            end
        end
    end

endmodule

// File: doc/rob.md
# rob

Reorder buffer directly downstream of the ID stage in the out-of-order core. It allocates one entry per decoded instruction in program order and returns the entry tag to ID for renaming. It also gives ID operand lookup by tag, records execution results, and retires completed instructions in order toward the regfile, at most one per cycle. It is a circular buffer with head/tail pointers, per-entry valid/done state, registered commit outputs and a global flush.

## Interface
- ROB_DEPTH, 16, number of entries; power of two, ≥ 4
- ROB_ADDR_WIDTH, 4, log2(ROB_DEPTH)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  discard all entries (mispredict/exception)
- id_valid  in  1  ID presents an instruction to allocate
- id_pc  in  32  instruction PC
- id_reg_write_en  in  1  instruction writes a register
- id_reg_write_addr  in  5  destination register
- id_ready  out  1  ROB can accept an allocation this cycle
- alloc_id  out  ROB_ADDR_WIDTH  tag assigned if allocation occurs this cycle
- read_id_1 / read_id_2  in  ROB_ADDR_WIDTH  operand tags from ID
- read_ready_1 / read_ready_2  out  1  tagged result available
- read_data_1 / read_data_2  out  32  tagged result value
- wb_en  in  1  execution result valid
- wb_id  in  ROB_ADDR_WIDTH  tag of result
- wb_data  in  32  result value
- commit_en  out  1  one instruction retired
- commit_pc  out  32  retired PC
- commit_reg_write_en  out  1  retired instruction writes regfile
- commit_reg_write_addr  out  5  retired destination
- commit_data  out  32  retired value

## Operation
- Entry fields: valid, done, pc, reg_write_en, reg_write_addr, data.
- head and tail are ROB_ADDR_WIDTH bits and wrap modulo ROB_DEPTH. count is ROB_ADDR_WIDTH+1 bits.
- full = (count == ROB_DEPTH); id_ready = !full (combinational, from state at cycle start).
- alloc_id = tail (combinational).
- Allocate when id_valid && id_ready:
  - entry[tail] gets valid=1, done=0 and the ID fields.
  - tail increments.
- Writeback when wb_en and entry[wb_id].valid: done=1 and data=wb_data. A writeback to an invalid entry is ignored.
- Commit when entry[head].valid && entry[head].done, evaluated at cycle start:
  - commit_* registers load the entry and commit_en is set to 1.
  - entry[head].valid is cleared and head increments.
  - Otherwise commit_en is set to 0. The other commit_* outputs hold their last values.
- count next value = count + alloc − commit.
- Read ports:
  - read_ready_n = entry.valid && entry.done, or (wb_en && wb_id == read_id_n && entry.valid).
  - The same-cycle writeback is forwarded: in that case read_data_n = wb_data, otherwise entry.data.
- Priority: reset > flush > {alloc, writeback, commit}; the last three are independent.
- flush: all valid=0, head=tail=count=0 and commit_en=0 on the next edge. Any alloc, writeback or commit in the same cycle is discarded.
- Full and committing in the same cycle: the allocation is still refused (no bypass); id_ready rises the next cycle.
- Writeback to the head entry: it commits on the following edge, not the same one.

## Timing
- Reset (rst=0 at an edge): head=tail=count=0, all valid/done=0, commit_en=0 and all commit_* outputs 0. Afterwards id_ready=1 and alloc_id=0.
- Allocation takes effect at the edge; the entry becomes visible to commit and read ports in the next cycle.
- Writeback at edge N makes head commit at edge N+1, so commit_en is high in cycle N+1.
- Minimum alloc-to-commit latency: 2 edges, when writeback arrives in the cycle after allocation.
- Throughput: 1 allocation, 1 writeback and 1 commit per cycle.
- Read ports are purely combinational.

## Test plan
- Reset: hold rst=0 for 2 cycles then release → id_ready=1, alloc_id=0, commit_en=0, commit_pc=0, count=0.
- In-order commit:
  - Stimulus: allocate PCs 0x100/0x104/0x108 (tags 0/1/2); writeback tag 1 with 0x11, then tag 0 with 0x22.
  - Response: commits 0x100 (data 0x22), then 0x104 (0x11) on consecutive cycles; 0x108 does not commit until tag 2 is written back.
- Full:
  - Stimulus: allocate 16 entries with no writeback, then hold id_valid.
  - Response: id_ready=0 after the 16th allocation and tail does not advance. Writeback tag 0 → commit, then id_ready=1 the cycle after the commit.
- Wrap-around: fill, then commit/allocate continuously for 40 instructions → alloc_id sequence 15→0 is seamless, commit PCs stay strictly in program order, and count never exceeds 16.
- Forwarding: entry 2 valid, not done; same cycle wb_en=1, wb_id=2, wb_data=0xDEADBEEF, read_id_1=2 → read_ready_1=1, read_data_1=0xDEADBEEF. read_id_2 pointing at an invalid entry → read_ready_2=0.
- Flush mid-operation: 5 entries live, head done, flush=1 together with id_valid and wb_en → next cycle commit_en=0, id_ready=1, alloc_id=0, and no entry commits afterwards.
